sync_divider_pipe: RTL

- Parametrised successor to the fixed fast/slow sync counter.
- Replaces the derived slow clock with a programmable clock-enable ("tick") divider on the single fast clock.
- Data passes through a capture register, a tick-gated synch register and two tick-gated decode stages, with valid tracking.
- Sits between the fast-domain data source and slow-rate consumers; every flop runs on fast_clk.

---
 rtl/sync_pkg.sv | 29 ++
 rtl/tick_divider.sv | 46 ++++
 rtl/sync_divider_pipe.sv | 88 ++++++++
 3 files changed

// File: rtl/sync_pkg.sv
// Shared constants and the stage decode function for the tick-gated sync pipeline.
// dec() works on a fixed maximum-width vector so any data width up to DecMaxWidth can use it.
package sync_pkg;

  localparam int unsigned DefaultWidth      = 4;
  localparam int unsigned DefaultDivW       = 2;
  localparam int unsigned DefaultResetRatio = 3;
  localparam int unsigned DecMaxWidth       = 64;

  // Bits at or above `width` come back as zero; callers slice off [width-1:0].
  function automatic logic [DecMaxWidth-1:0] dec(input logic [DecMaxWidth-1:0] s,
                                                 input int unsigned             width);
    logic [DecMaxWidth-1:0] o;
    o = '0;
    for (int unsigned i = 0; i < DecMaxWidth; i++) begin
      if (i == 0) begin
        o[i] = s[1] & s[0];
      end else if (i == 1) begin
        o[i] = s[1];
      end else if (i == width - 1) begin
        o[i] = s[i] | s[1];
      end else if (i < width - 1) begin
        o[i] = s[i] & s[1];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Programmable clock-enable divider: pulses slow_tick once every R+1 non-held cycles of fast_clk.
// R is taken live from div_ratio, or from RESET_RATIO while div_bypass is set.
module tick_divider
  import sync_pkg::*;
#(
  parameter int unsigned DIV_W       = DefaultDivW,
  parameter int unsigned RESET_RATIO = DefaultResetRatio
) (
  input  logic             fast_clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             div_bypass,
  input  logic             hold,
  output logic             slow_tick
);

  logic [DIV_W-1:0] cnt_d, cnt_q;
  logic [DIV_W-1:0] ratio_eff;

  always_comb begin
    ratio_eff = div_bypass ? DIV_W'(RESET_RATIO) : div_ratio;
  end

  // Using >= rather than == lets a ratio lowered below cnt fire on the next cycle instead of
  // running the counter up to wrap-around.
  always_comb begin
    slow_tick = !reset && !hold && (cnt_q >= ratio_eff);
  end

  // cnt never passes 2^DIV_W-1: at that value cnt >= R always holds, so it ticks or is held.
  always_comb begin
    cnt_d = cnt_q;
    if (!hold) begin
      cnt_d = slow_tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sync_divider_pipe.sv
// Capture register followed by three tick-gated stages (synch, decode, multiply) with valid
// tracking; everything runs on fast_clk and advances only on slow_tick.
module sync_divider_pipe
  import sync_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned DIV_W       = DefaultDivW,
  parameter int unsigned RESET_RATIO = DefaultResetRatio
) (
  input  logic             fast_clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             div_bypass,
  input  logic             hold,
  input  logic [WIDTH-1:0] data,
  output logic             slow_tick,
  output logic [WIDTH-1:0] multiply_reg,
  output logic             out_valid
);

  logic [WIDTH-1:0] shift_d, shift_q;
  logic [WIDTH-1:0] synch_d, synch_q;
  logic [WIDTH-1:0] decode_d, decode_q;
  logic [WIDTH-1:0] mult_d, mult_q;
  logic [2:0]       valid_d, valid_q;

  logic [DecMaxWidth-1:0] synch_ext, decode_ext;
  logic [DecMaxWidth-1:0] synch_dec, decode_dec;
  logic                   unused_dec_hi;

  tick_divider #(
    .DIV_W       (DIV_W),
    .RESET_RATIO (RESET_RATIO)
  ) u_tick_divider (
    .fast_clk   (fast_clk),
    .reset      (reset),
    .div_ratio  (div_ratio),
    .div_bypass (div_bypass),
    .hold       (hold),
    .slow_tick  (slow_tick)
  );

  always_comb begin
    synch_ext                = '0;
    synch_ext[WIDTH-1:0]     = synch_q;
    decode_ext               = '0;
    decode_ext[WIDTH-1:0]    = decode_q;
    synch_dec                = dec(synch_ext, WIDTH);
    decode_dec               = dec(decode_ext, WIDTH);
  end

  // Upper decode bits are always zero; fold them away so they do not read as dangling logic.
  assign unused_dec_hi = ^{synch_dec, decode_dec};

  always_comb begin
    shift_d  = data;
    synch_d  = synch_q;
    decode_d = decode_q;
    mult_d   = mult_q;
    valid_d  = valid_q;
    if (slow_tick) begin
      synch_d  = shift_q;
      decode_d = synch_dec[WIDTH-1:0];
      mult_d   = decode_dec[WIDTH-1:0];
      valid_d  = {valid_q[1:0], 1'b1};
    end
  end

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      shift_q  <= '0;
      synch_q  <= '0;
      decode_q <= '0;
      mult_q   <= '0;
      valid_q  <= '0;
    end else begin
      shift_q  <= shift_d;
      synch_q  <= synch_d;
      decode_q <= decode_d;
      mult_q   <= mult_d;
      valid_q  <= valid_d;
    end
  end

  assign multiply_reg = mult_q;
  assign out_valid    = valid_q[2];

endmodule
